// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and
// access geometry constants.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/dmem_word_array.sv
// Word-wide storage with synchronous write, asynchronous read and a
// synchronous clear; word 0 is tapped out for observation.
module dmem_word_array #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic [31:0]   word0
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];
    assign word0 = mem[0];

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage responder: holds the pipeline with StallM while a load or
// store waits out WAIT_CYCLES, then pulses MemDoneM (and AddrErrM on a bad address).
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MemDoneM,
    output logic        AddrErrM,
    output logic [31:0] test_value
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t             state;
    state_t             next_state;
    logic [CNT_W-1:0]   count;
    logic [31:0]        addr_q;
    logic [31:0]        data_q;
    logic               write_q;
    logic               req;
    logic               access_now;
    logic               addr_err;
    logic               mem_we;
    logic [31:0]        word_idx;
    logic [31:0]        rdata;

    assign req        = MemReadM | MemWriteM;
    assign word_idx   = addr_q >> $clog2(WORD_BYTES);
    assign addr_err   = (addr_q[1:0] != 2'b00) || (word_idx >= 32'(DEPTH));
    assign access_now = (state == BUSY) && (count == '0);
    assign mem_we     = access_now && write_q && !addr_err;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // DONE never looks at req: the old request is still on the bus there
    // and must not start a second access.
    always_comb begin
        next_state = state;
        StallM     = 1'b0;
        MemDoneM   = 1'b0;
        AddrErrM   = 1'b0;
        case (state)
            IDLE: begin
                StallM = req;
                if (req) begin
                    next_state = BUSY;
                end
            end
            BUSY: begin
                StallM = 1'b1;
                if (count == '0) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                MemDoneM   = 1'b1;
                AddrErrM   = addr_err;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (Reset) begin
            StallM   = 1'b0;
            MemDoneM = 1'b0;
            AddrErrM = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            count     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            write_q   <= 1'b0;
            ReadDataM <= '0;
        end else begin
            if (state == IDLE && req) begin
                addr_q  <= ALUOutM;
                data_q  <= WriteDataM;
                write_q <= MemWriteM;
                count   <= CNT_W'(WAIT_CYCLES);
            end else if (state == BUSY && count != '0) begin
                count <= count - 1'b1;
            end
            if (access_now && !write_q && !addr_err) begin
                ReadDataM <= rdata;
            end
        end
    end

    dmem_word_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (CLK),
        .reset (Reset),
        .we    (mem_we),
        .addr  (addr_q[AW+1:2]),
        .wdata (data_q),
        .rdata (rdata),
        .word0 (test_value)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stall length, done/error pulses,
// load data, reset abort and back-to-back requests at DEPTH=256, WAIT_CYCLES=2.
module tb_dmem_responder;

    logic        CLK;
    logic        Reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MemDoneM;
    logic        AddrErrM;
    logic [31:0] test_value;

    int checks = 0;
    int errors = 0;
    int stallA;
    int stallB;

    dmem_responder #(
        .DEPTH       (256),
        .WAIT_CYCLES (2)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MemDoneM   (MemDoneM),
        .AddrErrM   (AddrErrM),
        .test_value (test_value)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives one request at a negedge and follows it to its DONE cycle,
    // leaving the request asserted so the caller decides what comes next.
    task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] data,
                                 input logic expErr, input logic [31:0] expRead,
                                 input logic [31:0] expTest, output int stalls);
        bit done;
        @(negedge CLK);
        MemReadM   = rd;
        MemWriteM  = wr;
        ALUOutM    = addr;
        WriteDataM = data;
        #1;
        stalls = 0;
        done   = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            if (MemDoneM) begin
                done = 1;
            end else begin
                if (StallM) stalls++;
                @(negedge CLK);
            end
        end
        checkOutput({tag, ".done"},   32'(done),   32'd1);
        checkOutput({tag, ".stalls"}, 32'(stalls), 32'd4);
        checkOutput({tag, ".stallDone"}, 32'(StallM), 32'd0);
        checkOutput({tag, ".err"},    32'(AddrErrM), 32'(expErr));
        checkOutput({tag, ".rdata"},  ReadDataM, expRead);
        checkOutput({tag, ".test"},   test_value, expTest);
    endtask

    task automatic idleCycle(input string tag);
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        @(negedge CLK);
        checkOutput({tag, ".donePulse"}, 32'(MemDoneM), 32'd0);
        checkOutput({tag, ".stallIdle"}, 32'(StallM),   32'd0);
    endtask

    initial begin
        Reset      = 1'b1;
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        ALUOutM    = '0;
        WriteDataM = '0;

        @(negedge CLK);
        MemWriteM = 1'b1;
        #1;
        checkOutput("resetStall", 32'(StallM), 32'd0);
        MemWriteM = 1'b0;
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        checkOutput("rst.rdata", ReadDataM, 32'd0);
        checkOutput("rst.stall", 32'(StallM), 32'd0);
        checkOutput("rst.done",  32'(MemDoneM), 32'd0);
        checkOutput("rst.test",  test_value, 32'd0);

        applyStimulus("st0", 1'b0, 1'b1, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0, 32'hDEADBEEF, stallA);
        idleCycle("st0");
        applyStimulus("ld0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, stallA);
        idleCycle("ld0");
        applyStimulus("st8", 1'b0, 1'b1, 32'h8, 32'h11111111, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, stallA);
        idleCycle("st8");

        applyStimulus("stMis", 1'b0, 1'b1, 32'h6, 32'h1234, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, stallA);
        idleCycle("stMis");
        applyStimulus("ld4", 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, 32'hDEADBEEF, stallA);
        idleCycle("ld4");
        applyStimulus("ld8", 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h11111111, 32'hDEADBEEF, stallA);
        idleCycle("ld8");
        applyStimulus("ldOor", 1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 32'h11111111, 32'hDEADBEEF, stallA);
        idleCycle("ldOor");

        // Reset arrives two cycles into a store and must abort it cleanly.
        @(negedge CLK);
        MemWriteM  = 1'b1;
        ALUOutM    = 32'hC;
        WriteDataM = 32'h55;
        #1;
        checkOutput("abort.stallT", 32'(StallM), 32'd1);
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b1;
        #1;
        checkOutput("abort.stallRst", 32'(StallM), 32'd0);
        @(negedge CLK);
        Reset     = 1'b0;
        MemWriteM = 1'b0;
        #1;
        checkOutput("abort.stallAfter", 32'(StallM), 32'd0);
        checkOutput("abort.test", test_value, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            checkOutput("abort.noDone", 32'(MemDoneM), 32'd0);
        end
        applyStimulus("ldC", 1'b1, 1'b0, 32'hC, 32'h0, 1'b0, 32'h0, 32'h0, stallA);
        idleCycle("ldC");

        applyStimulus("st10", 1'b0, 1'b1, 32'h10, 32'hA5A5A5A5, 1'b0, 32'h0, 32'h0, stallA);
        idleCycle("st10");
        applyStimulus("b2bLd", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hA5A5A5A5, 32'h0, stallA);
        applyStimulus("b2bSt", 1'b1, 1'b1, 32'h10, 32'hCAFEF00D, 1'b0, 32'hA5A5A5A5, 32'h0, stallB);
        checkOutput("b2b.totalStall", 32'(stallA + stallB), 32'd8);
        idleCycle("b2bSt");
        applyStimulus("ld10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hCAFEF00D, 32'h0, stallA);
        idleCycle("ld10");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
